// File: rtl/benes_apply_pkg.sv
// Shared types and sizing helpers for the stage-serial Benes network.
package benes_apply_pkg;

  localparam int unsigned DEF_SIZE     = 32;
  localparam int unsigned DEF_TAGWIDTH = $clog2(DEF_SIZE);

  // Lane index tag for the default lane count.
  typedef logic [DEF_TAGWIDTH-1:0] lane_tag_t;

  // Controller state: idle, stepping through layers, holding the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of switch layers for a SIZE-lane Benes network.
  function automatic int unsigned calc_stages(input int unsigned size);
    return 2 * $clog2(size) - 1;
  endfunction

  // Control word width: one bit per 2x2 switch over all layers.
  function automatic int unsigned calc_bitwidth(input int unsigned size);
    return calc_stages(size) * (size / 2);
  endfunction

endpackage

// File: rtl/benes_layer.sv
// One combinational Benes switch layer with a runtime-selected gap of 1<<i_gap_sel.
module benes_layer
  import benes_apply_pkg::*;
#(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned TAGWIDTH  = $clog2(SIZE),
  parameter int unsigned GSELW     = $clog2(TAGWIDTH)
) (
  input  logic [GSELW-1:0]                 i_gap_sel,
  input  logic [SIZE/2-1:0]                i_ctrl,
  input  logic [SIZE-1:0][DATAWIDTH-1:0]   i_data,
  input  logic [SIZE-1:0][TAGWIDTH-1:0]    i_tag,
  output logic [SIZE-1:0][DATAWIDTH-1:0]   o_data_c,
  output logic [SIZE-1:0][TAGWIDTH-1:0]    o_tag_c
);

  localparam int unsigned NGAP = 1 << GSELW;

  logic [TAGWIDTH-1:0] w_gap;

  assign w_gap = TAGWIDTH'(1) << i_gap_sel;

  // Each lane either keeps its value or takes its partner's (lane ^ gap).
  // The governing switch index is the lane number with the gap bit removed.
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic [NGAP-1:0]     w_sw_by_gap;
    logic                w_swap;
    logic [TAGWIDTH-1:0] w_mate;

    for (genvar g = 0; g < NGAP; g++) begin : g_gap
      if (g < TAGWIDTH) begin : g_real
        localparam int unsigned GAP    = 1 << g;
        localparam int unsigned SW_IDX = ((k >> (g + 1)) << g) | (k & (GAP - 1));
        assign w_sw_by_gap[g] = i_ctrl[SW_IDX];
      end else begin : g_pad
        assign w_sw_by_gap[g] = 1'b0;
      end
    end

    assign w_swap      = w_sw_by_gap[i_gap_sel];
    assign w_mate      = TAGWIDTH'(k) ^ w_gap;
    assign o_data_c[k] = w_swap ? i_data[w_mate] : i_data[k];
    assign o_tag_c[k]  = w_swap ? i_tag[w_mate]  : i_tag[k];
  end

endmodule

// File: rtl/benes_apply.sv
// Stage-serial Benes network: applies one switch layer per cycle and returns
// the permuted lanes together with the realised lane permutation.
module benes_apply
  import benes_apply_pkg::*;
#(
  parameter  int unsigned SIZE      = 32,
  parameter  int unsigned DATAWIDTH = 32,
  localparam int unsigned TAGWIDTH  = $clog2(SIZE),
  localparam int unsigned STAGES    = calc_stages(SIZE),
  localparam int unsigned BITWIDTH  = calc_bitwidth(SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BITWIDTH-1:0]              in_ctrl,
  input  logic [SIZE-1:0][DATAWIDTH-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIZE-1:0][DATAWIDTH-1:0]   out_data,
  output logic [SIZE-1:0][TAGWIDTH-1:0]    out_perm,
  output logic                             busy
);

  localparam int unsigned HALF  = SIZE / 2;
  localparam int unsigned STGW  = TAGWIDTH + 1;
  localparam int unsigned GSELW = $clog2(TAGWIDTH);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [STGW-1:0]                r_stg;
  logic [STGW-1:0]                w_stg_nxt;
  logic [BITWIDTH-1:0]            r_ctrl;
  logic [BITWIDTH-1:0]            w_ctrl_nxt;
  logic [SIZE-1:0][DATAWIDTH-1:0] r_data;
  logic [SIZE-1:0][DATAWIDTH-1:0] w_data_nxt;
  logic [SIZE-1:0][TAGWIDTH-1:0]  r_perm;
  logic [SIZE-1:0][TAGWIDTH-1:0]  w_perm_nxt;
  logic                           r_in_ready;
  logic                           w_in_ready_nxt;
  logic                           r_out_valid;
  logic                           w_out_valid_nxt;
  logic                           r_busy;
  logic                           w_busy_nxt;

  logic [STGW-1:0]                w_mirror;
  logic [STGW-1:0]                w_gexp;
  logic [GSELW-1:0]               w_gap_sel;
  logic [SIZE-1:0][DATAWIDTH-1:0] w_layer_data;
  logic [SIZE-1:0][TAGWIDTH-1:0]  w_layer_tag;

  // Gap exponent follows 0,1,..,T-1,..,1,0 across the layers.
  assign w_mirror  = STGW'(STAGES - 1) - r_stg;
  assign w_gexp    = (r_stg < w_mirror) ? r_stg : w_mirror;
  assign w_gap_sel = GSELW'(w_gexp);

  // The control word is shifted down one layer per step, so the active
  // layer's switch bits always sit in the low HALF bits.
  benes_layer #(
    .SIZE      (SIZE),
    .DATAWIDTH (DATAWIDTH),
    .TAGWIDTH  (TAGWIDTH),
    .GSELW     (GSELW)
  ) u_layer (
    .i_gap_sel (w_gap_sel),
    .i_ctrl    (r_ctrl[HALF-1:0]),
    .i_data    (r_data),
    .i_tag     (r_perm),
    .o_data_c  (w_layer_data),
    .o_tag_c   (w_layer_tag)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_stg       <= '0;
      r_ctrl      <= '0;
      r_data      <= '0;
      r_perm      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stg       <= w_stg_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_data      <= w_data_nxt;
      r_perm      <= w_perm_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state, datapath update and next-cycle handshake flags.
  always_comb begin
    w_state_nxt = r_state;
    w_stg_nxt   = r_stg;
    w_ctrl_nxt  = r_ctrl;
    w_data_nxt  = r_data;
    w_perm_nxt  = r_perm;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_ctrl_nxt  = in_ctrl;
          w_data_nxt  = in_data;
          for (int k = 0; k < SIZE; k++) begin
            w_perm_nxt[k] = TAGWIDTH'(k);
          end
          w_stg_nxt   = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_data_nxt = w_layer_data;
        w_perm_nxt = w_layer_tag;
        w_ctrl_nxt = r_ctrl >> HALF;
        w_stg_nxt  = r_stg + STGW'(1);
        if (r_stg == STGW'(STAGES - 1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_data;
  assign out_perm  = r_perm;

endmodule

// File: tb/tb_benes_apply.sv
// Self-checking bench for benes_apply (SIZE=32, DATAWIDTH=32).
module tb_benes_apply;

  localparam int unsigned SIZE     = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned TW       = 5;
  localparam int unsigned STAGES   = 9;
  localparam int unsigned HALF     = 16;
  localparam int unsigned BITWIDTH = 144;

  typedef logic [SIZE-1:0][DW-1:0] data_vec_t;
  typedef logic [SIZE-1:0][TW-1:0] perm_vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_ctrl;
  data_vec_t           in_data;
  logic                out_valid;
  logic                out_ready;
  data_vec_t           out_data;
  perm_vec_t           out_perm;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  benes_apply #(.SIZE(SIZE), .DATAWIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_perm  (out_perm),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First differing lane, or -1 (used only to keep failure lines short).
  function automatic int bad_lane_d(input data_vec_t a, input data_vec_t b);
    for (int k = 0; k < SIZE; k++) if (a[k] !== b[k]) return k;
    return -1;
  endfunction

  function automatic int bad_lane_p(input perm_vec_t a, input perm_vec_t b);
    for (int k = 0; k < SIZE; k++) if (a[k] !== b[k]) return k;
    return -1;
  endfunction

  // Reference: apply the layers literally as lane-index swaps.
  task automatic model_perm(input logic [BITWIDTH-1:0] c, output perm_vec_t p);
    int unsigned lane[SIZE];
    int unsigned t, gap, pos, e;
    logic [BITWIDTH-1:0] cv;
    cv = c;
    for (int k = 0; k < SIZE; k++) lane[k] = k;
    for (int s = 0; s < STAGES; s++) begin
      e   = (s < int'(STAGES) - 1 - s) ? s : STAGES - 1 - s;
      gap = 1 << e;
      for (int j = 0; j < HALF; j++) begin
        pos = (j % gap) + 2 * gap * (j / gap);
        if (cv[0]) begin
          t              = lane[pos];
          lane[pos]      = lane[pos + gap];
          lane[pos + gap] = t;
        end
        cv = cv >> 1;
      end
    end
    for (int k = 0; k < SIZE; k++) p[k] = TW'(lane[k]);
  endtask

  function automatic data_vec_t gather(input data_vec_t d, input perm_vec_t p);
    data_vec_t r;
    for (int k = 0; k < SIZE; k++) r[k] = d[p[k]];
    return r;
  endfunction

  function automatic data_vec_t rand_data();
    data_vec_t r;
    for (int k = 0; k < SIZE; k++) r[k] = $urandom();
    return r;
  endfunction

  function automatic logic [BITWIDTH-1:0] rand_ctrl();
    return BITWIDTH'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Issue one request from IDLE and wait (bounded) for out_valid; lat=0 on timeout.
  task automatic run_req(input logic [BITWIDTH-1:0] c, input data_vec_t d, output int lat);
    in_ctrl   = c;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    step(); step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_data !== '0 || out_perm !== '0) begin
      failures++;
      $display("FAIL reset_outputs got data_lane0=%h perm_lane0=%h exp 0", out_data[0], out_perm[0]);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_identity();
    data_vec_t d, ed;
    perm_vec_t ep;
    int lat;
    for (int k = 0; k < SIZE; k++) begin
      d[k]  = DW'(k + 100);
      ed[k] = DW'(k + 100);
      ep[k] = TW'(k);
    end
    run_req('0, d, lat);
    checks++;
    if (lat != STAGES) begin
      failures++;
      $display("FAIL identity_latency got=%0d exp=%0d", lat, STAGES);
    end
    checks++;
    if (out_perm !== ep) begin
      failures++;
      $display("FAIL identity_perm lane=%0d got=%h exp=%h", bad_lane_p(out_perm, ep),
               out_perm[bad_lane_p(out_perm, ep)], ep[bad_lane_p(out_perm, ep)]);
    end
    checks++;
    if (out_data !== ed) begin
      failures++;
      $display("FAIL identity_data lane=%0d got=%h exp=%h", bad_lane_d(out_data, ed),
               out_data[bad_lane_d(out_data, ed)], ed[bad_lane_d(out_data, ed)]);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_flags got in_ready=%b busy=%b exp 0 1", in_ready, busy);
    end
    drain();
  endtask

  task automatic test_layer0();
    logic [BITWIDTH-1:0] c;
    data_vec_t d;
    perm_vec_t ep;
    int lat;
    c = '0;
    c[HALF-1:0] = '1;
    d = rand_data();
    for (int k = 0; k < SIZE; k++) ep[k] = TW'(k ^ 1);
    run_req(c, d, lat);
    checks++;
    if (out_perm !== ep) begin
      failures++;
      $display("FAIL layer0_perm lane=%0d got=%h exp=%h", bad_lane_p(out_perm, ep),
               out_perm[bad_lane_p(out_perm, ep)], ep[bad_lane_p(out_perm, ep)]);
    end
    checks++;
    if (out_data !== gather(d, ep)) begin
      failures++;
      $display("FAIL layer0_data lane0 got=%h exp=%h", out_data[0], d[1]);
    end
    drain();
  endtask

  task automatic test_all_ones();
    data_vec_t d;
    perm_vec_t ep;
    int lat;
    d = rand_data();
    for (int k = 0; k < SIZE; k++) ep[k] = TW'(k ^ 16);
    run_req('1, d, lat);
    checks++;
    if (out_perm !== ep) begin
      failures++;
      $display("FAIL allones_perm lane=%0d got=%h exp=%h", bad_lane_p(out_perm, ep),
               out_perm[bad_lane_p(out_perm, ep)], ep[bad_lane_p(out_perm, ep)]);
    end
    checks++;
    if (out_data[0] !== d[16]) begin
      failures++;
      $display("FAIL allones_data0 got=%h exp=%h", out_data[0], d[16]);
    end
    drain();
  endtask

  task automatic test_single_bits();
    logic [BITWIDTH-1:0] c;
    data_vec_t d;
    perm_vec_t ep;
    int lat;
    // First switch of the first layer: lanes 0 and 1.
    c = '0; c[0] = 1'b1;
    d = rand_data();
    for (int k = 0; k < SIZE; k++) ep[k] = TW'(k);
    ep[0] = TW'(1); ep[1] = TW'(0);
    run_req(c, d, lat);
    checks++;
    if (out_perm !== ep || out_data !== gather(d, ep)) begin
      failures++;
      $display("FAIL bit0_swap lane=%0d got=%h exp=%h", bad_lane_p(out_perm, ep),
               out_perm[bad_lane_p(out_perm, ep)], ep[bad_lane_p(out_perm, ep)]);
    end
    drain();
    // Last switch of the last layer: lanes 30 and 31.
    c = '0; c[BITWIDTH-1] = 1'b1;
    d = rand_data();
    for (int k = 0; k < SIZE; k++) ep[k] = TW'(k);
    ep[30] = TW'(31); ep[31] = TW'(30);
    run_req(c, d, lat);
    checks++;
    if (out_perm !== ep || out_data !== gather(d, ep)) begin
      failures++;
      $display("FAIL bit143_swap lane=%0d got=%h exp=%h", bad_lane_p(out_perm, ep),
               out_perm[bad_lane_p(out_perm, ep)], ep[bad_lane_p(out_perm, ep)]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [BITWIDTH-1:0] c;
    data_vec_t d, d2, hold_d;
    perm_vec_t p, hold_p, idp;
    int lat, bad, lat2;
    c = rand_ctrl();
    d = rand_data();
    d2 = rand_data();
    model_perm(c, p);
    for (int k = 0; k < SIZE; k++) idp[k] = TW'(k);
    run_req(c, d, lat);
    hold_d = gather(d, p);
    hold_p = p;
    in_ctrl  = '0;
    in_data  = d2;
    in_valid = 1'b1;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== hold_d || out_perm !== hold_p) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable bad_cycles=%0d exp=0 (out_valid=%b in_ready=%b)", bad, out_valid, in_ready);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_handshake got out_valid=%b in_ready=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL second_accept got busy=%b in_ready=%b exp 1 0", busy, in_ready);
    end
    lat2 = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (out_valid) begin
        lat2 = n;
        break;
      end
    end
    checks++;
    if (lat2 != STAGES || out_data !== d2 || out_perm !== idp) begin
      failures++;
      $display("FAIL second_result lat=%0d exp=%0d lane0 got=%h exp=%h", lat2, STAGES, out_data[0], d2[0]);
    end
    drain();
  endtask

  task automatic test_reset_midrun();
    logic [BITWIDTH-1:0] c;
    data_vec_t d;
    perm_vec_t ep;
    int lat;
    in_ctrl  = rand_ctrl();
    in_data  = rand_data();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 4; n++) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_busy got=%b exp=1", busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0 || out_perm !== '0) begin
      failures++;
      $display("FAIL midrun_reset got out_valid=%b in_ready=%b busy=%b data0=%h perm0=%h exp 0 1 0 0 0",
               out_valid, in_ready, busy, out_data[0], out_perm[0]);
    end
    step();
    rst = 1'b0;
    step();
    // Reversal 31-k is XOR with 31: gaps 1,2,4,8,16 from the first five layers.
    c = '0;
    c[5*HALF-1:0] = '1;
    d = rand_data();
    for (int k = 0; k < SIZE; k++) ep[k] = TW'(31 - k);
    run_req(c, d, lat);
    checks++;
    if (lat != STAGES || out_perm !== ep) begin
      failures++;
      $display("FAIL reversal_perm lat=%0d lane=%0d got=%h exp=%h", lat, bad_lane_p(out_perm, ep),
               out_perm[0], ep[0]);
    end
    checks++;
    if (out_data !== gather(d, ep)) begin
      failures++;
      $display("FAIL reversal_data lane0 got=%h exp=%h", out_data[0], d[31]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [BITWIDTH-1:0] c;
    data_vec_t d;
    perm_vec_t p, first_p;
    int hits[$];
    int overlap;
    int waited;
    c = rand_ctrl();
    d = rand_data();
    model_perm(c, p);
    first_p = '0;
    overlap = 0;
    in_ctrl = c;
    in_data = d;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    for (int n = 1; n <= 30; n++) begin
      step();
      if (out_valid && in_ready) overlap++;
      if (out_valid) begin
        hits.push_back(n);
        if (hits.size() == 1) first_p = out_perm;
      end
    end
    in_valid = 1'b0;
    waited = 0;
    while (busy && waited < 40) begin
      step();
      waited++;
    end
    out_ready = 1'b0;
    checks++;
    if (hits.size() != 2 || hits[0] != STAGES || hits[1] != 2 * STAGES + 2) begin
      failures++;
      $display("FAIL b2b_spacing got count=%0d first=%0d second=%0d exp 2 %0d %0d", hits.size(),
               (hits.size() > 0) ? hits[0] : -1, (hits.size() > 1) ? hits[1] : -1, STAGES, 2 * STAGES + 2);
    end
    checks++;
    if (overlap != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_exclusive overlap=%0d busy=%b exp 0 0", overlap, busy);
    end
    checks++;
    if (first_p !== p) begin
      failures++;
      $display("FAIL b2b_perm lane=%0d got=%h exp=%h", bad_lane_p(first_p, p),
               first_p[bad_lane_p(first_p, p)], p[bad_lane_p(first_p, p)]);
    end
  endtask

  task automatic test_random();
    logic [BITWIDTH-1:0] c;
    data_vec_t d, ed;
    perm_vec_t p;
    int lat;
    for (int it = 0; it < 20; it++) begin
      c = rand_ctrl();
      d = rand_data();
      model_perm(c, p);
      ed = gather(d, p);
      run_req(c, d, lat);
      checks++;
      if (lat != STAGES) begin
        failures++;
        $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, STAGES);
      end
      checks++;
      if (out_perm !== p) begin
        failures++;
        $display("FAIL rand_perm it=%0d lane=%0d got=%h exp=%h", it, bad_lane_p(out_perm, p),
                 out_perm[bad_lane_p(out_perm, p)], p[bad_lane_p(out_perm, p)]);
      end
      checks++;
      if (out_data !== ed) begin
        failures++;
        $display("FAIL rand_data it=%0d lane=%0d got=%h exp=%h", it, bad_lane_d(out_data, ed),
                 out_data[bad_lane_d(out_data, ed)], ed[bad_lane_d(out_data, ed)]);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_layer0();
    test_all_ones();
    test_single_bits();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/benes_apply.md
Name: benes_apply

Overview:
- Stage-serial Beneš network that consumes a control-bit word and applies it to a SIZE-lane data vector.
- The control word is the one produced by the permutation-to-control-bits block. This block is the receiving end of that ctrl interface.
- Runs one switch layer per cycle. Returns the permuted data together with the realised permutation (lane tags), so the control generator can be checked in-system.
- Sits between the ctrl generator and the vector crossbar datapath.

Parameters:
- SIZE, 32, number of lanes; power of two, ≥4.
- DATAWIDTH, 32, bits per data lane.
- TAGWIDTH, $clog2(SIZE), localparam, lane index width.
- STAGES, 2*TAGWIDTH-1, localparam, number of switch layers.
- BITWIDTH, STAGES*(SIZE/2), localparam, control word width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_ctrl  in  BITWIDTH  control bits; bit s*(SIZE/2)+j controls switch j of layer s.
- in_data  in  [SIZE-1:0][DATAWIDTH-1:0]  data lanes.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  [SIZE-1:0][DATAWIDTH-1:0]  permuted lanes.
- out_perm  out  [SIZE-1:0][TAGWIDTH-1:0]  realised permutation: out_data[k] = in_data[out_perm[k]].
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, RUN, DONE. Stage counter stg, TAGWIDTH+1 bits wide.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_ctrl to ctrl_q and in_data to data_q; set perm_q[k]=k; set stg=0; go to RUN.
- RUN, each cycle (in_ready=0):
  - gap = 1 << min(stg, STAGES-1-stg).
  - For each j in 0..SIZE/2-1: pos = (j mod gap) + 2*gap*(j/gap).
  - If ctrl_q[stg*(SIZE/2)+j]: swap data_q[pos]↔data_q[pos+gap] and perm_q[pos]↔perm_q[pos+gap]. All swaps in a layer are disjoint and happen in parallel.
  - stg++. On the edge that applies stg==STAGES-1, go to DONE.
- DONE:
  - out_valid=1; out_data=data_q; out_perm=perm_q.
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Latency: accept edge at t0 → out_valid high after edge t0+STAGES (9 cycles for SIZE=32).
- Throughput: one request per STAGES+2 cycles. in_ready is low in RUN and DONE; no overlap.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, stg=0, in_ready=1, out_valid=0, busy=0.
  - data_q, ctrl_q and perm_q cleared to 0, so out_data=0 and out_perm=0. Any in-flight request is discarded.
- Timing rules:
  - in_valid asserted in RUN/DONE is ignored; the source must hold it.
  - out_ready while not in DONE has no effect.
  - out_valid and in_ready are never both high.
- Layer gap sequence is 1,2,…,SIZE/2,…,2,1. Layer STAGES/2 uses gap SIZE/2.
- Contract: a ctrl word generated from permutation π gives out_perm == π.

Decomposition:
- Shared xbar package: lane_tag_t (logic [TAGWIDTH-1:0]), STAGES/BITWIDTH helper functions, and the state enum.
- Sub-module benes_layer: one combinational layer. Inputs are gap select, SIZE/2 ctrl bits, data and tags; outputs are swapped data and tags. Instantiated once and muxed by stg.

Test Plan:
- in_ctrl=0, in_data[k]=k+100 → out_data[k]=k+100, out_perm[k]=k, out_valid 9 cycles after accept.
- in_ctrl bits 0..15 =1, rest 0 → out_perm[k]=k^1 (e.g. out_perm[0]=1, out_perm[31]=30).
- in_ctrl all ones → out_perm[k]=k^16 (XOR of all gaps); out_data[0]=in_data[16].
- Only bit 0 set → lanes 0,1 swapped. Only bit 143 set → lanes 30,31 swapped. All other lanes unchanged.
- out_ready held low 5 cycles in DONE → out_valid and outputs stable; in_ready=0; a second in_valid is not accepted until the cycle after the handshake.
- rst pulsed mid-RUN (stg=4) → out_valid=0, in_ready=1 immediately. The next request with ctrl from the generator for the reversal π[k]=31-k yields out_perm[k]=31-k.
